// File: rtl/call_stack_pc_pkg.sv
// Shared CPU definitions for the call/return path: widths, reset vector,
// branch opcodes and the per-cycle stack operation encoding.
package call_stack_pc_pkg;

    localparam int CPU_AW       = 10;
    localparam int CPU_DEPTH    = 8;
    localparam int RESET_VECTOR = 0;

    localparam logic [5:0] OPC_BSR = 6'h2C;
    localparam logic [5:0] OPC_RET = 6'h2D;

    // What the PC/stack does this cycle once HOLD and RESET are out of the way.
    typedef enum logic [2:0] {
        OP_STEP     = 3'd0,
        OP_CALL     = 3'd1,
        OP_CALL_OVF = 3'd2,
        OP_RET      = 3'd3,
        OP_RET_UNF  = 3'd4
    } stack_op_e;

endpackage

// File: rtl/lifo_mem.sv
// Return-address storage: registered write, combinational read.
// Not reset; only entries below the current depth are ever meaningful.
module lifo_mem
    import call_stack_pc_pkg::*;
#(
    parameter int AW    = CPU_AW,
    parameter int DEPTH = CPU_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [AW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [AW-1:0]            rdata
);

    logic [AW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack_pc.sv
// Program counter with a hardware return-address stack for bsr/ret.
// Return wins over call when both decode in the same cycle.
module call_stack_pc
    import call_stack_pc_pkg::*;
#(
    parameter int AW    = CPU_AW,
    parameter int DEPTH = CPU_DEPTH
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   HOLD,
    input  logic                   bsr_det,
    input  logic                   ret_det,
    input  logic [AW-1:0]          target,
    output logic [AW-1:0]          PC,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   stack_empty,
    output logic                   stack_full,
    output logic                   overflow_err,
    output logic                   underflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = PW + 1;

    stack_op_e     op;
    logic          push;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] top_addr;
    logic [PW-1:0] rd_addr;

    assign pc_inc      = PC + AW'(1);
    assign stack_empty = (depth == '0);
    assign stack_full  = (depth == DW'(DEPTH));
    assign rd_addr     = depth[PW-1:0] - PW'(1);
    assign push        = !RESET && !HOLD && (op == OP_CALL);

    always_comb begin
        op = OP_STEP;
        if (ret_det) begin
            op = stack_empty ? OP_RET_UNF : OP_RET;
        end else if (bsr_det) begin
            op = stack_full ? OP_CALL_OVF : OP_CALL;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            PC            <= AW'(RESET_VECTOR);
            depth         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (!HOLD) begin
            case (op)
                OP_CALL: begin
                    PC    <= target;
                    depth <= depth + DW'(1);
                end
                OP_RET: begin
                    PC    <= top_addr;
                    depth <= depth - DW'(1);
                end
                OP_CALL_OVF: begin
                    PC           <= pc_inc;
                    overflow_err <= 1'b1;
                end
                OP_RET_UNF: begin
                    PC            <= pc_inc;
                    underflow_err <= 1'b1;
                end
                default: PC <= pc_inc;
            endcase
        end
    end

    // Push writes the slot at the current depth; pop reads depth-1.
    lifo_mem #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_lifo_mem (
        .clk   (CLK),
        .we    (push),
        .waddr (depth[PW-1:0]),
        .wdata (pc_inc),
        .raddr (rd_addr),
        .rdata (top_addr)
    );

endmodule

// File: tb/tb_call_stack_pc.sv
// Directed bench for call_stack_pc: reset, sequential fetch, calls/returns,
// overflow/underflow, PC wrap, HOLD and reset-during-hold.
module tb_call_stack_pc;

    logic       CLK = 1'b0;
    logic       RESET, HOLD, bsr_det, ret_det;
    logic [9:0] target;
    logic [9:0] PC;
    logic [3:0] depth;
    logic       stack_empty, stack_full, overflow_err, underflow_err;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];
    logic [9:0] m_pc;

    call_stack_pc dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .HOLD          (HOLD),
        .bsr_det       (bsr_det),
        .ret_det       (ret_det),
        .target        (target),
        .PC            (PC),
        .depth         (depth),
        .stack_empty   (stack_empty),
        .stack_full    (stack_full),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic h, input logic b, input logic r, input logic [9:0] t);
        HOLD = h; bsr_det = b; ret_det = r; target = t;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 10'h0);
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        RESET = 1'b0;
        set_in(0, 0, 0, 10'h0);

        // reset state and sequential fetch
        do_reset();
        chk("rst_pc", PC, 0);
        chk("rst_depth", depth, 0);
        chk("rst_empty", stack_empty, 1);
        chk("rst_full", stack_full, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_unf", underflow_err, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("seq_pc", PC, i);
        end
        chk("seq_empty", stack_empty, 1);

        // single call and return from 0x010
        for (int i = 0; i < 11; i++) tick();
        chk("pc_010", PC, 10'h010);
        set_in(0, 1, 0, 10'h200);
        tick();
        chk("call_pc", PC, 10'h200);
        chk("call_depth", depth, 1);
        chk("call_empty", stack_empty, 0);
        set_in(0, 0, 0, 10'h0);
        tick();
        chk("idle1_pc", PC, 10'h201);
        tick();
        chk("idle2_pc", PC, 10'h202);
        set_in(0, 0, 1, 10'h0);
        tick();
        chk("ret_pc", PC, 10'h011);
        chk("ret_depth", depth, 0);

        // nested calls from PC=5
        do_reset();
        set_in(0, 0, 0, 10'h0);
        for (int i = 0; i < 5; i++) tick();
        chk("nest_start", PC, 5);
        set_in(0, 1, 0, 10'h100); tick();
        chk("nest_c1", PC, 10'h100);
        set_in(0, 1, 0, 10'h180); tick();
        chk("nest_c2", PC, 10'h180);
        set_in(0, 1, 0, 10'h1C0); tick();
        chk("nest_c3", PC, 10'h1C0);
        chk("nest_depth3", depth, 3);
        set_in(0, 0, 1, 10'h0);
        tick(); chk("nest_r1", PC, 10'h181); chk("nest_d2", depth, 2);
        tick(); chk("nest_r2", PC, 10'h101); chk("nest_d1", depth, 1);
        tick(); chk("nest_r3", PC, 10'h006); chk("nest_d0", depth, 0);

        // nine calls into an eight-deep stack, then unwind
        do_reset();
        m_pc = 10'h0;
        for (int i = 0; i < 9; i++) begin
            set_in(0, 1, 0, 10'(10'h040 + i * 10'h021));
            tick();
            if (i < 8) begin
                exp_q.push_back(m_pc + 10'd1);
                m_pc = target;
                chk("fill_pc", PC, m_pc);
                chk("fill_depth", depth, i + 1);
                chk("fill_full", stack_full, (i == 7) ? 1 : 0);
                chk("fill_ovf", overflow_err, 0);
            end else begin
                m_pc = m_pc + 10'd1;
                chk("ovf_pc", PC, m_pc);
                chk("ovf_depth", depth, 8);
                chk("ovf_err", overflow_err, 1);
            end
        end
        set_in(0, 0, 1, 10'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("unwind_pc", PC, exp_q.pop_back());
            chk("unwind_depth", depth, 7 - i);
        end
        chk("unwind_empty", stack_empty, 1);
        chk("unwind_ovf_sticky", overflow_err, 1);
        chk("unwind_unf", underflow_err, 0);

        // underflow and wrap at 0x3FF, then call at 0x3FF pushes 0x000
        do_reset();
        for (int i = 0; i < 1023; i++) tick();
        chk("wrap_pc", PC, 10'h3FF);
        set_in(0, 0, 1, 10'h0); tick();
        chk("unf_pc", PC, 10'h000);
        chk("unf_err", underflow_err, 1);
        chk("unf_depth", depth, 0);
        set_in(0, 1, 0, 10'h3FF); tick();
        chk("to3ff_pc", PC, 10'h3FF);
        set_in(0, 1, 0, 10'h123); tick();
        chk("c3ff_pc", PC, 10'h123);
        chk("c3ff_depth", depth, 2);
        set_in(0, 0, 1, 10'h0); tick();
        chk("r3ff_pc", PC, 10'h000);
        tick();
        chk("r3ff_pc2", PC, 10'h001);
        chk("unf_sticky", underflow_err, 1);

        // HOLD freezes state; reset overrides HOLD
        do_reset();
        set_in(0, 1, 0, 10'h100); tick();
        set_in(0, 1, 0, 10'h180); tick();
        chk("hold_pre_pc", PC, 10'h180);
        chk("hold_pre_depth", depth, 2);
        set_in(1, 1, 0, 10'h2AA);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_pc", PC, 10'h180);
            chk("hold_depth", depth, 2);
        end
        RESET = 1'b1; tick(); RESET = 1'b0;
        chk("hold_rst_pc", PC, 0);
        chk("hold_rst_depth", depth, 0);
        set_in(0, 0, 1, 10'h0); tick();
        chk("post_rst_unf", underflow_err, 1);
        chk("post_rst_pc", PC, 1);
        set_in(1, 0, 1, 10'h0); tick();
        chk("hold_unf_sticky", underflow_err, 1);
        chk("hold_pc2", PC, 1);

        // return has priority over a simultaneous call
        set_in(0, 1, 0, 10'h050); tick();
        chk("prio_call_pc", PC, 10'h050);
        set_in(0, 1, 1, 10'h2AA); tick();
        chk("prio_pc", PC, 10'h002);
        chk("prio_depth", depth, 0);
        chk("prio_ovf", overflow_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
